// File: rtl/echo_pipe_serializer_pkg.sv
// Shared connect package: EchoRequest message layout, frame constants, beat FSM encoding.
// Pure declarations; no timing or backpressure of its own.
package echo_pipe_serializer_pkg;

  localparam logic [15:0] HDR_LEN         = 16'd3;
  localparam int          BEATS_PER_FRAME = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] tag;
  } EchoRequest_data;

  typedef enum logic [$clog2(BEATS_PER_FRAME)-1:0] {
    S_HDR = 2'd0,
    S_TAG = 2'd1,
    S_HI  = 2'd2,
    S_LO  = 2'd3
  } beat_state_t;

  // Word presented on the narrow link for a given beat of a message.
  function automatic logic [31:0] beat_word(beat_state_t st, EchoRequest_data m);
    case (st)
      S_HDR:   return {HDR_LEN, m.tag[15:0]};
      S_TAG:   return m.tag;
      S_HI:    return m.data[63:32];
      default: return m.data[31:0];
    endcase
  endfunction

endpackage

// File: rtl/echo_msg_fifo.sv
// Circular message buffer of DEPTH entries (power of two, >= 2), WIDTH bits wide.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: full derives from registered occupancy only; push ignored when full, pop ignored when empty.
module echo_msg_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             wr_en;
  logic             rd_en;

  assign full     = (occ == FULL_OCC);
  assign empty    = (occ == '0);
  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      occ <= occ + 1'b1;
      else if (rd_en && !wr_en) occ <= occ - 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/echo_pipe_serializer.sv
// Serialises 96-bit EchoRequest messages into 4-beat 32-bit frames (HDR, TAG, HI, LO).
// Latency: message accepted in cycle t emits its HDR beat in cycle t+1; frames run back-to-back.
// Backpressure: out RDY low stalls the beat FSM in place; pipe RDY depends only on buffer occupancy.
module echo_pipe_serializer
  import echo_pipe_serializer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pipe_enq_vld,
  input  logic [95:0] pipe_enq_dat,
  output logic        pipe_enq_rdy,
  output logic        out_enq_vld,
  output logic [31:0] out_enq_dat,
  output logic        out_enq_last,
  input  logic        out_enq_rdy,
  output logic [15:0] frame_count
);

  EchoRequest_data head;
  logic            buf_full;
  logic            buf_empty;
  logic            pop;
  beat_state_t     state;
  logic [15:0]     frame_cnt;

  echo_msg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(EchoRequest_data))
  ) u_msg_fifo (
    .clk      (CLK),
    .rst_n    (nRST),
    .push     (pipe_enq_vld),
    .push_dat (pipe_enq_dat),
    .pop      (pop),
    .head_dat (head),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  assign pipe_enq_rdy = !buf_full;
  assign out_enq_vld  = !buf_empty && out_enq_rdy;
  assign out_enq_dat  = beat_word(state, head);
  assign out_enq_last = (state == S_LO);
  // Head leaves on the LO beat so the next HDR can go out the very next cycle.
  assign pop          = out_enq_vld && (state == S_LO);
  assign frame_count  = frame_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= S_HDR;
      frame_cnt <= '0;
    end else if (out_enq_vld) begin
      case (state)
        S_HDR:   state <= S_TAG;
        S_TAG:   state <= S_HI;
        S_HI:    state <= S_LO;
        default: begin
          state     <= S_HDR;
          frame_cnt <= frame_cnt + 16'd1;
        end
      endcase
    end
  end

endmodule
